generic_rr_grant_hold: RTL and testbench

Registered round-robin arbiter that turns a request vector into a held, one-hot grant with a valid/ready handshake toward the consuming stage. It sits directly upstream of the one-hot/zero-one-hot checker in the debug trace arbitration path. Its `gnt_onehot` output is the vector that checker qualifies, and it is guaranteed zero-one-hot by construction. A saturating stall counter flags a consumer that holds off a grant for too long.

---
 rtl/generic_rr_grant_hold_if.sv | 24 ++
 rtl/generic_rr_grant_hold.sv | 64 ++++++
 tb/tb_generic_rr_grant_hold.sv | 120 ++++++++++++
 3 files changed

// File: rtl/generic_rr_grant_hold_if.sv
// generic_rr_grant_hold_if: request/grant handshake bundle between requesters, arbiter and consumer.
interface generic_rr_grant_hold_if #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ),
    parameter int STALL_W = 8
);
    logic [NUM_REQ-1:0] req;
    logic               lock;
    logic               gnt_ready;
    logic               gnt_valid;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IDX_W-1:0]   gnt_idx;
    logic [STALL_W-1:0] stall_cnt;
    logic               stall_err;
    logic               stall_clr;
    modport master (
        input  req, lock, gnt_ready, stall_clr,
        output gnt_valid, gnt_onehot, gnt_idx, stall_cnt, stall_err
    );
    modport slave (
        output req, lock, gnt_ready, stall_clr,
        input  gnt_valid, gnt_onehot, gnt_idx, stall_cnt, stall_err
    );
endinterface

// File: rtl/generic_rr_grant_hold.sv
// generic_rr_grant_hold: registered round-robin arbiter with held one-hot grant, lock and stall watchdog.
module generic_rr_grant_hold #(
    parameter int NUM_REQ   = 8,
    parameter int IDX_W     = $clog2(NUM_REQ),
    parameter int STALL_W   = 8,
    parameter int STALL_MAX = 200
) (
    input logic clk,
    input logic reset_n,
    generic_rr_grant_hold_if.master bus
);
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   base;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [STALL_W-1:0] cnt_nxt;
    logic               xfer;
    logic               slot;
    logic               lock_hit;
    logic               any_req;

    function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W-1:0] b, input int i);
        int j;
        j = int'(b) + i;
        return IDX_W'(j >= NUM_REQ ? j - NUM_REQ : j);
    endfunction

    assign xfer     = bus.gnt_valid & bus.gnt_ready;
    assign slot     = !bus.gnt_valid | bus.gnt_ready;
    assign lock_hit = xfer & bus.lock & bus.req[bus.gnt_idx];
    assign any_req  = |bus.req;
    // an unlocked transfer moves the pointer this same edge, so scan from the winner being retired
    assign base     = (xfer & !bus.lock) ? bus.gnt_idx : ptr;
    assign win_oh   = any_req ? NUM_REQ'(1) << win_idx : '0;
    assign cnt_nxt  = (bus.gnt_valid & !bus.gnt_ready)
                    ? (&bus.stall_cnt ? bus.stall_cnt : bus.stall_cnt + 1'b1) : '0;

    // descending loop so the nearest set bit after base is the last write
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--)
            if (bus.req[wrap(base, i)]) win_idx = wrap(base, i);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.gnt_valid  <= 1'b0;
            bus.gnt_onehot <= '0;
            bus.gnt_idx    <= '0;
            bus.stall_cnt  <= '0;
            bus.stall_err  <= 1'b0;
            ptr            <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (slot) begin
                bus.gnt_valid  <= any_req;
                bus.gnt_idx    <= lock_hit ? bus.gnt_idx : win_idx;
                bus.gnt_onehot <= lock_hit ? bus.gnt_onehot : win_oh;
            end
            if (xfer & !bus.lock) ptr <= bus.gnt_idx;
            bus.stall_cnt <= bus.stall_clr ? '0 : cnt_nxt;
            bus.stall_err <= !bus.stall_clr & (bus.stall_err | (cnt_nxt == STALL_W'(STALL_MAX)));
        end
    end
endmodule

// File: tb/tb_generic_rr_grant_hold.sv
// tb_generic_rr_grant_hold: table-driven check of the 8-way arbiter plus hand sequences for wrap and saturation.
module tb_generic_rr_grant_hold;
    logic clk = 1'b0;
    logic rst8_n = 1'b0;
    logic rst5_n = 1'b0;
    int   nvec = 0;
    int   nbad = 0;

    always #5 clk = ~clk;

    generic_rr_grant_hold_if #(.NUM_REQ(8)) b8 ();
    generic_rr_grant_hold_if #(.NUM_REQ(5)) b5 ();

    generic_rr_grant_hold #(.NUM_REQ(8), .STALL_MAX(4)) dut8 (.clk(clk), .reset_n(rst8_n), .bus(b8));
    generic_rr_grant_hold #(.NUM_REQ(5)) dut5 (.clk(clk), .reset_n(rst5_n), .bus(b5));

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       lock;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [2:0] idx;
        logic [7:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic [7:0] req, input logic lock, input logic rdy,
                       input logic clr, input logic v, input logic [2:0] idx, input logic [7:0] cnt,
                       input logic err);
        vecs.push_back('{rst_n, req, lock, rdy, clr, v, idx, cnt, err});
    endtask

    task automatic check(input string name, input int n, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b8.req = '0; b8.lock = 0; b8.gnt_ready = 0; b8.stall_clr = 0;
        b5.req = '0; b5.lock = 0; b5.gnt_ready = 0; b5.stall_clr = 0;
        // reset, then full request round robin 0..7 and wrap to 0
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(1, 8'hFF, 0, 1, 0, 1, 3'(i % 8), 0, 0);
        // hold under backpressure, granted bit dropped mid-hold
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h24, 0, 0, 0, 1, 2, 0, 0);
        for (int i = 1; i <= 10; i++) add(1, i <= 5 ? 8'h24 : 8'h20, 0, 0, 0, 1, 2, 8'(i), i >= 4);
        add(1, 8'h20, 0, 1, 0, 1, 5, 0, 1);
        add(1, 8'h00, 0, 0, 1, 1, 5, 0, 0);
        add(1, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        // lock burst then release
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h11, 1, 1, 0, 1, 0, 0, 0);
        add(1, 8'h11, 1, 1, 0, 1, 0, 0, 0);
        add(1, 8'h11, 1, 1, 0, 1, 0, 0, 0);
        add(1, 8'h11, 0, 1, 0, 1, 4, 0, 0);
        add(1, 8'h11, 0, 1, 0, 1, 0, 0, 0);
        // reset while a grant is held
        add(1, 8'h11, 0, 0, 0, 1, 0, 1, 0);
        add(0, 8'h11, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h80, 0, 1, 0, 1, 7, 0, 0);

        foreach (vecs[n]) begin
            rst8_n = vecs[n].rst_n;
            b8.req = vecs[n].req;
            b8.lock = vecs[n].lock;
            b8.gnt_ready = vecs[n].rdy;
            b8.stall_clr = vecs[n].clr;
            tick();
            check("valid", n, 64'(b8.gnt_valid), 64'(vecs[n].v));
            check("idx", n, 64'(b8.gnt_idx), 64'(vecs[n].idx));
            check("onehot", n, 64'(b8.gnt_onehot), vecs[n].v ? 64'(8'(1) << vecs[n].idx) : 64'h0);
            check("stall_cnt", n, 64'(b8.stall_cnt), 64'(vecs[n].cnt));
            check("stall_err", n, 64'(b8.stall_err), 64'(vecs[n].err));
        end

        // counter saturates at 255 and error stays set
        rst8_n = 0; b8.req = 8'h01; b8.gnt_ready = 0; b8.lock = 0; b8.stall_clr = 0;
        tick();
        rst8_n = 1;
        for (int i = 0; i < 300; i++) tick();
        check("sat_cnt", 0, 64'(b8.stall_cnt), 64'd255);
        check("sat_err", 0, 64'(b8.stall_err), 64'd1);
        check("sat_idx", 0, 64'(b8.gnt_idx), 64'd0);

        // 5-way wrap: pointer starts at 4, must wrap 4 -> 0 without unused codes
        rst5_n = 0; b5.gnt_ready = 1;
        tick();
        check("w5_rst_valid", 0, 64'(b5.gnt_valid), 64'd0);
        rst5_n = 1; b5.req = 5'b10000;
        tick();
        check("w5_idx", 1, 64'(b5.gnt_idx), 64'd4);
        tick();
        check("w5_idx", 2, 64'(b5.gnt_idx), 64'd4);
        check("w5_oh", 2, 64'(b5.gnt_onehot), 64'h10);
        b5.req = 5'b00110;
        tick();
        check("w5_idx", 3, 64'(b5.gnt_idx), 64'd1);
        tick();
        check("w5_idx", 4, 64'(b5.gnt_idx), 64'd2);
        tick();
        check("w5_idx", 5, 64'(b5.gnt_idx), 64'd1);
        check("w5_oh", 5, 64'(b5.gnt_onehot), 64'h02);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
